mult_hilo_unit: RTL and testbench

Issue and writeback stage wrapped around the 16×16 shift-add multiplier. It accepts a multiply request from the CPU datapath and converts signed operands to magnitudes. It launches the multiplier through its St/Idle/Done handshake, then sign-corrects the 32-bit product into the architectural HI/LO registers. It also stalls reads or writes of HI/LO while a multiply is outstanding.

---
 rtl/mult_hilo_unit_pkg.sv | 31 +++
 rtl/mult_hilo_unit_if.sv | 51 +++++
 rtl/mult_hilo_unit_sign_adj.sv | 22 ++
 rtl/mult_hilo_unit.sv | 143 ++++++++++++++
 tb/tb_mult_hilo_unit.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_hilo_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_hilo_pkg
//  Description : Shared types, default width and operand-magnitude helper for
//                the HI/LO multiply issue/writeback unit.
//  Revision    : 1.0  initial release
// ============================================================================
package mult_hilo_pkg;

   // Default operand width; HI and LO are each this wide.
   localparam int W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      WRITE = 2'd3
   } mh_state_t;

   // Unsigned magnitude of an operand. The most negative signed value maps
   // onto itself, which is the correct unsigned magnitude.
   function automatic logic [W_DEF-1:0] mag(input logic [W_DEF-1:0] x,
                                            input logic             sgn);
      if (sgn && x[W_DEF-1]) begin
         return -x;
      end
      return x;
   endfunction

endpackage : mult_hilo_pkg
`default_nettype wire

// File: rtl/mult_hilo_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_hilo_unit_if
//  Description : CPU-side request/HI-LO access bus and multiplier-side
//                St/Idle/Done bus of the HI/LO multiply unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface mult_hilo_unit_if
   import mult_hilo_pkg::*;
#(
   parameter int W = W_DEF
);
   // CPU datapath side
   logic           Req;
   logic           Sgn;
   logic [W-1:0]   OpA;
   logic [W-1:0]   OpB;
   logic           Ack;
   logic           Busy;
   logic           RdHi;
   logic           RdLo;
   logic           WrHi;
   logic           WrLo;
   logic [W-1:0]   WrData;
   logic [W-1:0]   HiOut;
   logic [W-1:0]   LoOut;
   logic           Stall;
   // Multiplier side
   logic           MulSt;
   logic [W-1:0]   MulA;
   logic [W-1:0]   MulB;
   logic           MulIdle;
   logic           MulDone;
   logic [2*W-1:0] MulProd;

   // The HI/LO unit itself
   modport slave (
      input  Req, Sgn, OpA, OpB, RdHi, RdLo, WrHi, WrLo, WrData,
      input  MulIdle, MulDone, MulProd,
      output Ack, Busy, HiOut, LoOut, Stall, MulSt, MulA, MulB
   );

   // The surrounding datapath and multiplier
   modport master (
      output Req, Sgn, OpA, OpB, RdHi, RdLo, WrHi, WrLo, WrData,
      output MulIdle, MulDone, MulProd,
      input  Ack, Busy, HiOut, LoOut, Stall, MulSt, MulA, MulB
   );

endinterface : mult_hilo_unit_if
`default_nettype wire

// File: rtl/mult_hilo_unit_sign_adj.sv
`default_nettype none
// ============================================================================
//  Module      : mult_sign_adj
//  Description : Applies the result sign to the unsigned magnitude product
//                using full-width two's-complement negation.
//  Revision    : 1.0  initial release
// ============================================================================
module mult_sign_adj #(
   parameter int W = 16
) (
   input  wire logic [2*W-1:0] prod,
   input  wire logic           neg,
   output logic      [2*W-1:0] result
);

   // Negate across the whole 2W-bit product so the borrow reaches HI.
   always_comb begin
      result = neg ? -prod : prod;
   end

endmodule : mult_sign_adj
`default_nettype wire

// File: rtl/mult_hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_hilo_unit
//  Description : Issue/writeback stage around the shift-add multiplier.
//                Converts operands to magnitudes, drives the St/Idle/Done
//                handshake, sign-corrects the product into HI/LO and stalls
//                HI/LO accesses while a multiply is outstanding.
//  Revision    : 1.0  initial release
// ============================================================================
module mult_hilo_unit
   import mult_hilo_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  wire logic         Clk,
   input  wire logic         Rst_n,
   mult_hilo_unit_if.slave   bus
);

   mh_state_t      state_q,  state_d;
   logic [W-1:0]   hi_q,     hi_d;
   logic [W-1:0]   lo_q,     lo_d;
   logic [W-1:0]   mul_a_q,  mul_a_d;
   logic [W-1:0]   mul_b_q,  mul_b_d;
   logic           mul_st_q, mul_st_d;
   logic           neg_q,    neg_d;
   logic [2*W-1:0] prod_q,   prod_d;

   logic [W-1:0]   mag_a;
   logic [W-1:0]   mag_b;
   logic [2*W-1:0] signed_prod;
   logic           ack;
   logic           busy;

   // Operand magnitudes: shared helper at the default width, inline otherwise.
   generate
      if (W == W_DEF) begin : g_mag_pkg
         assign mag_a = mag(bus.OpA, bus.Sgn);
         assign mag_b = mag(bus.OpB, bus.Sgn);
      end else begin : g_mag_generic
         assign mag_a = (bus.Sgn && bus.OpA[W-1]) ? -bus.OpA : bus.OpA;
         assign mag_b = (bus.Sgn && bus.OpB[W-1]) ? -bus.OpB : bus.OpB;
      end
   endgenerate

   mult_sign_adj #(
      .W      (W)
   ) u_sign_adj (
      .prod   (prod_q),
      .neg    (neg_q),
      .result (signed_prod)
   );

   // Accept only when idle and the multiplier is free; never during reset.
   always_comb begin
      busy = (state_q != IDLE);
      ack  = Rst_n & (state_q == IDLE) & bus.Req & bus.MulIdle;
   end

   // Next-state and register-update logic for the issue/writeback sequence.
   always_comb begin
      state_d  = state_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      mul_a_d  = mul_a_q;
      mul_b_d  = mul_b_q;
      mul_st_d = mul_st_q;
      neg_d    = neg_q;
      prod_d   = prod_q;
      case (state_q)
         IDLE: begin
            // Direct writes land even if a request is accepted this cycle;
            // WRITE later overwrites them.
            if (bus.WrHi) hi_d = bus.WrData;
            if (bus.WrLo) lo_d = bus.WrData;
            if (ack) begin
               mul_a_d  = mag_a;
               mul_b_d  = mag_b;
               neg_d    = bus.Sgn & (bus.OpA[W-1] ^ bus.OpB[W-1]);
               mul_st_d = 1'b1;
               state_d  = START;
            end
         end
         START: begin
            // Hold start until the multiplier shows it has begun.
            if (!bus.MulIdle) begin
               mul_st_d = 1'b0;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (bus.MulDone) begin
               prod_d  = bus.MulProd;
               state_d = WRITE;
            end
         end
         WRITE: begin
            {hi_d, lo_d} = signed_prod;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and architectural registers with synchronous active-low reset.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q  <= IDLE;
         hi_q     <= '0;
         lo_q     <= '0;
         mul_a_q  <= '0;
         mul_b_q  <= '0;
         mul_st_q <= 1'b0;
         neg_q    <= 1'b0;
         prod_q   <= '0;
      end else begin
         state_q  <= state_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         mul_a_q  <= mul_a_d;
         mul_b_q  <= mul_b_d;
         mul_st_q <= mul_st_d;
         neg_q    <= neg_d;
         prod_q   <= prod_d;
      end
   end

   // Output drive; HI/LO reads show register contents only.
   always_comb begin
      bus.Ack   = ack;
      bus.Busy  = busy;
      bus.Stall = busy & (bus.RdHi | bus.RdLo | bus.WrHi | bus.WrLo);
      bus.HiOut = hi_q;
      bus.LoOut = lo_q;
      bus.MulSt = mul_st_q;
      bus.MulA  = mul_a_q;
      bus.MulB  = mul_b_q;
   end

endmodule : mult_hilo_unit
`default_nettype wire

// File: tb/tb_mult_hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_hilo_unit
//  Description : Scoreboard bench for mult_hilo_unit with a behavioural
//                shift-add multiplier model on the St/Idle/Done bus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mult_hilo_unit;

   logic Clk = 1'b0;
   logic Rst_n;
   logic force_busy;

   always #5 Clk = ~Clk;

   mult_hilo_unit_if #(.W(16)) bus ();

   mult_hilo_unit #(
      .W     (16)
   ) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus.slave)
   );

   // Multiplier model: several cycles of work after a start, Done pulses
   // with Idle returning. force_busy pins it busy and ignores reset.
   logic        mdl_idle;
   logic        mdl_done;
   logic [31:0] mdl_prod;
   logic [2:0]  mdl_cnt;
   logic [15:0] mdl_a;
   logic [15:0] mdl_b;

   assign bus.MulIdle = mdl_idle;
   assign bus.MulDone = mdl_done;
   assign bus.MulProd = mdl_prod;

   always @(posedge Clk) begin
      if (force_busy) begin
         mdl_idle <= 1'b0;
         mdl_done <= 1'b0;
         mdl_cnt  <= 3'd0;
      end else if (!Rst_n) begin
         mdl_idle <= 1'b1;
         mdl_done <= 1'b0;
         mdl_cnt  <= 3'd0;
         mdl_prod <= 32'd0;
         mdl_a    <= 16'd0;
         mdl_b    <= 16'd0;
      end else begin
         mdl_done <= 1'b0;
         if (mdl_cnt != 3'd0) begin
            mdl_cnt <= mdl_cnt - 3'd1;
            if (mdl_cnt == 3'd1) begin
               mdl_done <= 1'b1;
               mdl_prod <= 32'(mdl_a) * 32'(mdl_b);
               mdl_idle <= 1'b1;
            end
         end else if (bus.MulSt && mdl_idle) begin
            mdl_idle <= 1'b0;
            mdl_cnt  <= 3'd4;
            mdl_a    <= bus.MulA;
            mdl_b    <= bus.MulB;
         end else begin
            mdl_idle <= 1'b1;
         end
      end
   end

   int          checks  = 0;
   int          errors  = 0;
   int          ack_cnt = 0;
   logic [31:0] exp_q[$];
   logic [31:0] op_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: compares launched magnitudes on each MulSt rise and HI/LO on
   // each Busy fall that is not caused by reset.
   logic busy_prev = 1'b0;
   logic st_prev   = 1'b0;
   logic rstn_prev = 1'b0;
   logic [31:0] mon_e;

   always @(negedge Clk) begin
      if (bus.Ack === 1'b1) ack_cnt++;
      if (bus.MulSt === 1'b1 && !st_prev) begin
         if (op_q.size() == 0) begin
            chk("mul_ops_unexpected", {bus.MulA, bus.MulB}, 32'hxxxx_xxxx);
         end else begin
            mon_e = op_q.pop_front();
            chk("mul_ops", {bus.MulA, bus.MulB}, mon_e);
         end
      end
      if (busy_prev && bus.Busy === 1'b0 && rstn_prev) begin
         if (exp_q.size() == 0) begin
            chk("hilo_unexpected", {bus.HiOut, bus.LoOut}, 32'hxxxx_xxxx);
         end else begin
            mon_e = exp_q.pop_front();
            chk("hilo", {bus.HiOut, bus.LoOut}, mon_e);
         end
      end
      st_prev   = (bus.MulSt === 1'b1);
      busy_prev = (bus.Busy === 1'b1);
      rstn_prev = Rst_n;
   end

   task automatic drive_req(input logic sgn, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] ea, input logic [15:0] eb,
                            input logic [31:0] e, input bit push_res);
      op_q.push_back({ea, eb});
      if (push_res) exp_q.push_back(e);
      bus.Sgn = sgn;
      bus.OpA = a;
      bus.OpB = b;
      bus.Req = 1'b1;
   endtask

   task automatic wait_ack();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge Clk);
         if (bus.Ack === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      chk("ack_seen", 32'(got), 32'd1);
      @(posedge Clk);
      #1;
      bus.Req = 1'b0;
   endtask

   task automatic wait_idle();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge Clk);
         if (bus.Busy === 1'b0) begin
            got = 1'b1;
            break;
         end
      end
      chk("idle_reached", 32'(got), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  ack0;
      int  seen;
      bit  got;
      Rst_n      = 1'b0;
      force_busy = 1'b0;
      bus.Req    = 1'b0;
      bus.Sgn    = 1'b0;
      bus.OpA    = '0;
      bus.OpB    = '0;
      bus.RdHi   = 1'b0;
      bus.RdLo   = 1'b0;
      bus.WrHi   = 1'b0;
      bus.WrLo   = 1'b0;
      bus.WrData = '0;

      // Reset state
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      chk("rst_hi",    32'(bus.HiOut), 32'd0);
      chk("rst_lo",    32'(bus.LoOut), 32'd0);
      chk("rst_mulst", 32'(bus.MulSt), 32'd0);
      chk("rst_mula",  32'(bus.MulA),  32'd0);
      chk("rst_mulb",  32'(bus.MulB),  32'd0);
      chk("rst_busy",  32'(bus.Busy),  32'd0);
      chk("rst_ack",   32'(bus.Ack),   32'd0);
      @(posedge Clk); #1;
      Rst_n = 1'b1;

      // Unsigned 3 x 5
      @(posedge Clk); #1;
      ack0 = ack_cnt;
      drive_req(1'b0, 16'd3, 16'd5, 16'd3, 16'd5, 32'h0000_000F, 1'b1);
      wait_ack();
      wait_idle();
      chk("t1_ack_pulses", 32'(ack_cnt - ack0), 32'd1);

      // Signed 0x8000 x 2
      @(posedge Clk); #1;
      drive_req(1'b1, 16'h8000, 16'h0002, 16'h8000, 16'h0002, 32'hFFFF_0000, 1'b1);
      wait_ack();
      wait_idle();

      // Signed -1 x -1
      @(posedge Clk); #1;
      drive_req(1'b1, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0001, 32'h0000_0001, 1'b1);
      wait_ack();
      wait_idle();

      // Unsigned 0xFFFF x 0xFFFF issued in the first idle cycle after WRITE
      #2;
      drive_req(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1);
      #1;
      chk("b2b_ack", 32'(bus.Ack), 32'd1);
      @(posedge Clk); #1;
      bus.Req = 1'b0;
      wait_idle();

      // Accesses while busy: stall, HI write suppressed
      @(posedge Clk); #1;
      drive_req(1'b0, 16'h1234, 16'h0100, 16'h1234, 16'h0100, 32'h0012_3400, 1'b1);
      wait_ack();
      bus.RdLo   = 1'b1;
      bus.WrHi   = 1'b1;
      bus.WrData = 16'hDEAD;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if (bus.Busy === 1'b1) begin
            chk("t5_stall_busy", 32'(bus.Stall), 32'd1);
            chk("t5_hi_held",    32'(bus.HiOut), 32'h0000_FFFE);
         end else begin
            chk("t5_stall_done", 32'(bus.Stall), 32'd0);
            chk("t5_lo_done",    32'(bus.LoOut), 32'h0000_3400);
            bus.RdLo = 1'b0;
            bus.WrHi = 1'b0;
            got = 1'b1;
            break;
         end
      end
      chk("t5_completed", 32'(got), 32'd1);
      @(negedge Clk);
      chk("t5_hi_after", 32'(bus.HiOut), 32'h0000_0012);

      // Direct LO write together with an accepted request
      @(posedge Clk); #1;
      drive_req(1'b0, 16'd3, 16'd5, 16'd3, 16'd5, 32'h0000_000F, 1'b1);
      bus.WrLo   = 1'b1;
      bus.WrData = 16'h1234;
      wait_ack();
      bus.WrLo = 1'b0;
      @(negedge Clk);
      chk("t6_lo_direct", 32'(bus.LoOut), 32'h0000_1234);
      wait_idle();

      // Reset during WAIT; multiplier stays busy across it
      @(posedge Clk); #1;
      drive_req(1'b0, 16'd7, 16'd9, 16'd7, 16'd9, 32'd0, 1'b0);
      wait_ack();
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge Clk);
         if (bus.Busy === 1'b1 && bus.MulSt === 1'b0 && bus.MulIdle === 1'b0) begin
            got = 1'b1;
            break;
         end
      end
      chk("t7_wait_reached", 32'(got), 32'd1);
      @(posedge Clk); #1;
      force_busy = 1'b1;
      Rst_n      = 1'b0;
      @(posedge Clk); #1;
      Rst_n = 1'b1;
      @(negedge Clk);
      chk("t7_hi",    32'(bus.HiOut), 32'd0);
      chk("t7_lo",    32'(bus.LoOut), 32'd0);
      chk("t7_busy",  32'(bus.Busy),  32'd0);
      chk("t7_mulst", 32'(bus.MulSt), 32'd0);
      @(posedge Clk); #1;
      drive_req(1'b0, 16'd2, 16'd3, 16'd2, 16'd3, 32'h0000_0006, 1'b1);
      seen = 0;
      repeat (6) begin
         @(negedge Clk);
         if (bus.Ack === 1'b1) seen++;
      end
      chk("t7_no_ack_mul_busy", 32'(seen), 32'd0);
      @(posedge Clk); #1;
      force_busy = 1'b0;
      wait_ack();
      wait_idle();

      @(negedge Clk);
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      chk("op_q_drained",  32'(op_q.size()),  32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mult_hilo_unit
`default_nettype wire
